// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one byte UART TX among NUM_CH requesters, sending each value as "ddd"+TERM_CHAR.
// States: IDLE no work | ARB grant one channel | CONV double-dabble | SEND launch byte | WAIT await tx_done.
module uart_tx_scheduler #(
  parameter int         NUM_CH    = 4,
  parameter int         DATA_W    = 10,
  parameter logic [7:0] TERM_CHAR = 8'h0A,
  localparam int        CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic                     tx_done,
  output logic                     tx_start,
  output logic [7:0]               tx_byte,
  output logic [NUM_CH-1:0]        grant,
  output logic                     busy,
  output logic                     frame_done,
  output logic [CHW-1:0]           cur_ch
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, ARB, CONV, SEND, WAIT} state_t;

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   pending, pending_nxt;
  logic [CHW-1:0]      rr_ptr;
  logic [CHW-1:0]      sel;
  logic                sel_hit;
  logic [DATA_W-1:0]   data_sel, data_sat;
  logic [DATA_W-1:0]   bin_q, bin_step;
  logic [11:0]         bcd_q, bcd_adj, bcd_step;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          idx_q;
  logic [7:0]          byte_q;
  logic [CHW-1:0]      cur_ch_q;

  function automatic logic [7:0] byte_for(input logic [1:0] i, input logic [11:0] b);
    case (i)
      2'd0:    return 8'h30 + {4'h0, b[11:8]};
      2'd1:    return 8'h30 + {4'h0, b[7:4]};
      2'd2:    return 8'h30 + {4'h0, b[3:0]};
      default: return TERM_CHAR;
    endcase
  endfunction

  // First pending channel at or after rr_ptr, with wrap.
  always_comb begin
    sel     = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!sel_hit && pending[(int'(rr_ptr) + i) % NUM_CH]) begin
        sel     = CHW'((int'(rr_ptr) + i) % NUM_CH);
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    data_sel = i_data[sel*DATA_W +: DATA_W];
    if (32'(data_sel) > 32'd999) data_sat = DATA_W'(999);
    else                         data_sat = data_sel;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < 3; d++) begin
      if (bcd_adj[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_adj[4*d +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[10:0], bin_q[DATA_W-1]};
    bin_step = bin_q << 1;
  end

  // A request landing in the granting ARB cycle is absorbed by the clear.
  assign pending_nxt = (pending | req) & ~grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|pending) state_nxt = ARB;
      ARB:  state_nxt = CONV;
      CONV: if (cnt_q == CW'(1)) state_nxt = SEND;
      SEND: state_nxt = WAIT;
      WAIT: if (tx_done) state_nxt = (idx_q == 2'd3) ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant      = '0;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    tx_byte    = byte_q;
    cur_ch     = cur_ch_q;
    case (state)
      ARB:  if (sel_hit) grant = NUM_CH'(1) << sel;
      SEND: tx_start = 1'b1;
      WAIT: frame_done = tx_done && (idx_q == 2'd3);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      rr_ptr   <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= 8'h00;
      cur_ch_q <= '0;
    end else begin
      pending <= pending_nxt;
      case (state)
        ARB: begin
          rr_ptr   <= (sel == CHW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
          cur_ch_q <= sel;
          bin_q    <= data_sat;
          bcd_q    <= '0;
          cnt_q    <= CW'(DATA_W);
        end
        CONV: begin
          bin_q <= bin_step;
          bcd_q <= bcd_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            idx_q  <= 2'd0;
            byte_q <= byte_for(2'd0, bcd_step);
          end
        end
        WAIT: begin
          if (tx_done && idx_q != 2'd3) begin
            idx_q  <= idx_q + 2'd1;
            byte_q <= byte_for(idx_q + 2'd1, bcd_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
